// File: rtl/xvc_pkg.sv
// Shared types and defaults for the XVC JTAG shift engine.
package xvc_pkg;

    localparam int WORD_W_DEF   = 32;
    localparam int HALF_W_DEF   = 16;
    localparam int DEFAULT_HALF = 4;

    // Engine states. SHIFT_LO/SHIFT_HI are the two TCK half-periods of one bit.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_EMIT     = 3'd4
    } xvc_state_e;

endpackage

// File: rtl/xvc_tck_phase_counter.sv
// TCK half-period timer: loaded with the half-period on entry to a phase,
// counts (half-1) down to 0 and reports phase_done while at 0.
module xvc_tck_phase_counter #(
    parameter int HALF_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [HALF_W-1:0] half,
    output logic              phase_done
);

    logic [HALF_W-1:0] cnt;

    // Reload at phase entry, otherwise count down and park at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= half - HALF_W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - HALF_W'(1);
        end
    end

    assign phase_done = (cnt == '0);

endmodule

// File: rtl/xvc_jtag_shifter.sv
// Bit-level JTAG engine for one XVC "shift:" command: consumes TMS/TDI words,
// toggles TCK at the programmed half-period and returns packed TDO words.
//
// Handshakes: every stream (start, vec, tdo) transfers on a rising clock edge
// where valid && ready are both high. A producer holds valid and its payload
// stable until that edge; ready may depend only on engine state, never on valid.
module xvc_jtag_shifter
    import xvc_pkg::*;
#(
    parameter int WORD_W       = WORD_W_DEF,
    parameter int HALF_W       = HALF_W_DEF,
    parameter int DEFAULT_HALF = xvc_pkg::DEFAULT_HALF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [31:0]       num_bits,
    input  logic              vec_valid,
    output logic              vec_ready,
    input  logic [WORD_W-1:0] vec_tms,
    input  logic [WORD_W-1:0] vec_tdi,
    output logic              tdo_valid,
    input  logic              tdo_ready,
    output logic [WORD_W-1:0] tdo_data,
    output logic              tdo_last,
    input  logic              tck_half_valid,
    input  logic [HALF_W-1:0] tck_half,
    output logic              busy,
    output logic              jtag_tck,
    output logic              jtag_tms,
    output logic              jtag_tdi,
    input  logic              jtag_tdo,
    output xvc_state_e        dbg_state
);

    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    xvc_state_e        state, state_next;
    logic [31:0]       remaining, rem_next;
    logic [IDX_W-1:0]  index, idx_next;
    logic [WORD_W-1:0] tms_w, tms_w_next;
    logic [WORD_W-1:0] tdi_w, tdi_w_next;
    logic [WORD_W-1:0] tdo_sr, tdo_sr_next;
    logic [HALF_W-1:0] half_q;
    logic              phase_load;
    logic              phase_done;

    assign dbg_state = state;

    // A fresh phase starts whenever the FSM enters one of the two shift states.
    assign phase_load = ((state_next == ST_SHIFT_LO) || (state_next == ST_SHIFT_HI))
                        && (state_next != state);

    xvc_tck_phase_counter #(
        .HALF_W (HALF_W)
    ) u_phase (
        .clock      (clock),
        .reset      (reset),
        .load       (phase_load),
        .half       (half_q),
        .phase_done (phase_done)
    );

    // Next-state logic plus next values of the datapath registers.
    always_comb begin
        state_next  = state;
        rem_next    = remaining;
        idx_next    = index;
        tms_w_next  = tms_w;
        tdi_w_next  = tdi_w;
        tdo_sr_next = tdo_sr;
        case (state)
            ST_IDLE: begin
                if (start_valid) begin
                    rem_next = num_bits;
                    if (num_bits != 32'd0) begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (vec_valid) begin
                    tms_w_next  = vec_tms;
                    tdi_w_next  = vec_tdi;
                    tdo_sr_next = '0;
                    idx_next    = '0;
                    state_next  = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                // Leaving LO is the edge that raises TCK: capture TDO here.
                if (phase_done) begin
                    tdo_sr_next[index] = jtag_tdo;
                    state_next         = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_done) begin
                    rem_next = (remaining != 32'd0) ? remaining - 32'd1 : 32'd0;
                    idx_next = index + IDX_W'(1);
                    if ((rem_next == 32'd0) || (index == IDX_LAST)) begin
                        state_next = ST_EMIT;
                    end else begin
                        state_next = ST_SHIFT_LO;
                    end
                end
            end
            ST_EMIT: begin
                if (tdo_ready) begin
                    state_next = (remaining != 32'd0) ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            index     <= '0;
            tms_w     <= '0;
            tdi_w     <= '0;
            tdo_sr    <= '0;
        end else begin
            state     <= state_next;
            remaining <= rem_next;
            index     <= idx_next;
            tms_w     <= tms_w_next;
            tdi_w     <= tdi_w_next;
            tdo_sr    <= tdo_sr_next;
        end
    end

    // Half-period register; only writable while idle, 0 maps to 1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            half_q <= HALF_W'(DEFAULT_HALF);
        end else if ((state == ST_IDLE) && tck_half_valid) begin
            half_q <= (tck_half == '0) ? HALF_W'(1) : tck_half;
        end
    end

    // Registered outputs, derived from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_ready <= 1'b1;
            busy        <= 1'b0;
            vec_ready   <= 1'b0;
            tdo_valid   <= 1'b0;
            tdo_data    <= '0;
            tdo_last    <= 1'b0;
            jtag_tck    <= 1'b0;
            jtag_tms    <= 1'b0;
            jtag_tdi    <= 1'b0;
        end else begin
            start_ready <= (state_next == ST_IDLE);
            busy        <= (state_next != ST_IDLE);
            vec_ready   <= (state_next == ST_LOAD);
            tdo_valid   <= (state_next == ST_EMIT);
            jtag_tck    <= (state_next == ST_SHIFT_HI);
            // TMS/TDI change only when a bit's low phase begins, otherwise hold.
            if (state_next == ST_SHIFT_LO) begin
                jtag_tms <= tms_w_next[idx_next];
                jtag_tdi <= tdi_w_next[idx_next];
            end
            if ((state == ST_SHIFT_HI) && (state_next == ST_EMIT)) begin
                tdo_data <= tdo_sr_next;
                tdo_last <= (rem_next == 32'd0);
            end
        end
    end

endmodule

// File: tb/tb_xvc_jtag_shifter.sv
// Directed bench for xvc_jtag_shifter with TDO looped back to TDI.
module tb_xvc_jtag_shifter;
    import xvc_pkg::*;

    logic        clock;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] num_bits;
    logic        vec_valid;
    logic        vec_ready;
    logic [31:0] vec_tms;
    logic [31:0] vec_tdi;
    logic        tdo_valid;
    logic        tdo_ready;
    logic [31:0] tdo_data;
    logic        tdo_last;
    logic        tck_half_valid;
    logic [15:0] tck_half;
    logic        busy;
    logic        jtag_tck;
    logic        jtag_tms;
    logic        jtag_tdi;
    logic        jtag_tdo;
    xvc_state_e  dbg_state;

    assign jtag_tdo = jtag_tdi;

    xvc_jtag_shifter dut (
        .clock          (clock),
        .reset          (reset),
        .start_valid    (start_valid),
        .start_ready    (start_ready),
        .num_bits       (num_bits),
        .vec_valid      (vec_valid),
        .vec_ready      (vec_ready),
        .vec_tms        (vec_tms),
        .vec_tdi        (vec_tdi),
        .tdo_valid      (tdo_valid),
        .tdo_ready      (tdo_ready),
        .tdo_data       (tdo_data),
        .tdo_last       (tdo_last),
        .tck_half_valid (tck_half_valid),
        .tck_half       (tck_half),
        .busy           (busy),
        .jtag_tck       (jtag_tck),
        .jtag_tms       (jtag_tms),
        .jtag_tdi       (jtag_tdi),
        .jtag_tdo       (jtag_tdo),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- vector table ----------------
    typedef struct {
        int          nb;
        logic        load_half;
        logic [15:0] half;
        int          exp_half;
        logic [15:0] mid_half;
        int          stall;
        logic [31:0] tms0;
        logic [31:0] tms1;
        logic [31:0] tdi0;
        logic [31:0] tdi1;
        logic [63:0] exp_tms;
        int          nwords;
        logic [32:0] exp0;   // {last, data}
        logic [32:0] exp1;
    } vec_t;

    vec_t vecs[8];
    vec_t post_abort;

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // ---------------- monitor ----------------
    int          exp_half = 4;
    int          rises = 0;
    int          hi_len = 0;
    int          lo_len = 0;
    int          hi_bad = 0;
    int          lo_bad = 0;
    int          stall_bad = 0;
    int          vec_cnt = 0;
    logic        prev_tck = 1'b0;
    logic [63:0] tms_cap = '0;

    always @(posedge clock) begin
        #1;
        if (jtag_tck && !prev_tck) begin
            rises++;
            tms_cap = {jtag_tms, tms_cap[63:1]};
        end
        prev_tck = jtag_tck;
        if (jtag_tck) begin
            hi_len++;
        end else begin
            if ((hi_len != 0) && (hi_len != exp_half)) hi_bad++;
            hi_len = 0;
        end
        if (dbg_state == ST_SHIFT_LO) begin
            lo_len++;
        end else begin
            if ((lo_len != 0) && (lo_len != exp_half)) lo_bad++;
            lo_len = 0;
        end
        if (tdo_valid && jtag_tck) stall_bad++;
        if (vec_ready) vec_cnt++;
    end

    // ---------------- driver ----------------
    task automatic run_vec(input vec_t v, input int tag);
        int r0, hb0, lb0, sb0;
        logic [32:0] got;
        logic [32:0] exp_w;
        logic [63:0] tms_seen;
        if (v.load_half) begin
            tck_half_valid = 1'b1;
            tck_half       = v.half;
            @(negedge clock);
            tck_half_valid = 1'b0;
        end
        exp_half = v.exp_half;
        r0  = rises;
        hb0 = hi_bad;
        lb0 = lo_bad;
        sb0 = stall_bad;
        if (v.nwords >= 1) exp_q.push_back(v.exp0);
        if (v.nwords >= 2) exp_q.push_back(v.exp1);
        for (int k = 0; k < 200 && !start_ready; k++) @(negedge clock);
        start_valid = 1'b1;
        num_bits    = v.nb;
        @(negedge clock);
        start_valid = 1'b0;
        for (int w = 0; w < v.nwords; w++) begin
            for (int k = 0; k < 2000 && !vec_ready; k++) @(negedge clock);
            if (!vec_ready) begin
                check($sformatf("v%0d_vec_ready_timeout", tag), {63'd0, vec_ready}, 64'd1);
                return;
            end
            vec_valid = 1'b1;
            vec_tms   = (w == 0) ? v.tms0 : v.tms1;
            vec_tdi   = (w == 0) ? v.tdi0 : v.tdi1;
            @(negedge clock);
            vec_valid = 1'b0;
            if ((w == 0) && (v.mid_half != 16'd0)) begin
                tck_half_valid = 1'b1;
                tck_half       = v.mid_half;
                @(negedge clock);
                tck_half_valid = 1'b0;
            end
            for (int k = 0; k < 5000 && !tdo_valid; k++) @(negedge clock);
            if (!tdo_valid) begin
                check($sformatf("v%0d_tdo_valid_timeout", tag), {63'd0, tdo_valid}, 64'd1);
                return;
            end
            repeat (v.stall) @(negedge clock);
            got   = {tdo_last, tdo_data};
            exp_w = exp_q.pop_front();
            check($sformatf("v%0d_word%0d", tag, w), {31'd0, got}, {31'd0, exp_w});
            tdo_ready = 1'b1;
            @(negedge clock);
            tdo_ready = 1'b0;
        end
        check($sformatf("v%0d_idle_after", tag), {62'd0, start_ready, busy}, 64'd2);
        check($sformatf("v%0d_tck_edges", tag), rises - r0, v.nb);
        check($sformatf("v%0d_hi_phase_len", tag), hi_bad - hb0, 0);
        check($sformatf("v%0d_lo_phase_len", tag), lo_bad - lb0, 0);
        check($sformatf("v%0d_tck_during_emit", tag), stall_bad - sb0, 0);
        tms_seen = tms_cap >> (64 - v.nb);
        check($sformatf("v%0d_tms_bits", tag), tms_seen, v.exp_tms);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int r0, vc0;
        //           nb  ld    half  eh  mid  st  tms0          tms1          tdi0          tdi1          exp_tms                nw  exp0                  exp1
        vecs[0] = '{ 8, 1'b0, 16'd0, 4, 16'd0, 0, 32'h00000000, 32'h00000000, 32'h000000A5, 32'h00000000, 64'h0,                  1, {1'b1, 32'h000000A5}, 33'h0};
        vecs[1] = '{40, 1'b0, 16'd0, 4, 16'd0,10, 32'h00000001, 32'h000000C0, 32'hDEADBEEF, 32'hFFFFFF3C, 64'h000000C0_00000001,   2, {1'b0, 32'hDEADBEEF}, {1'b1, 32'h0000003C}};
        vecs[2] = '{32, 1'b1, 16'd3, 3, 16'd0, 3, 32'h80000000, 32'h00000000, 32'h12345678, 32'h00000000, 64'h00000000_80000000,   1, {1'b1, 32'h12345678}, 33'h0};
        vecs[3] = '{ 1, 1'b1, 16'd1, 1, 16'd0, 0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 64'h1,                  1, {1'b1, 32'h00000001}, 33'h0};
        vecs[4] = '{ 5, 1'b1, 16'd0, 1, 16'd0, 0, 32'h0000000A, 32'h00000000, 32'h00000015, 32'h00000000, 64'hA,                  1, {1'b1, 32'h00000015}, 33'h0};
        vecs[5] = '{33, 1'b1, 16'd2, 2, 16'd0, 2, 32'h00000000, 32'h00000001, 32'h80000001, 32'hFFFFFFFF, 64'h00000001_00000000,   2, {1'b0, 32'h80000001}, {1'b1, 32'h00000001}};
        vecs[6] = '{ 4, 1'b1, 16'd2, 2, 16'd9, 0, 32'h00000005, 32'h00000000, 32'h00000005, 32'h00000000, 64'h5,                  1, {1'b1, 32'h00000005}, 33'h0};
        vecs[7] = '{ 2, 1'b0, 16'd0, 2, 16'd0, 0, 32'h00000002, 32'h00000000, 32'h00000003, 32'h00000000, 64'h2,                  1, {1'b1, 32'h00000003}, 33'h0};
        post_abort = '{4, 1'b0, 16'd0, 4, 16'd0, 0, 32'h00000000, 32'h00000000, 32'h00000009, 32'h00000000, 64'h0,              1, {1'b1, 32'h00000009}, 33'h0};

        reset          = 1'b0;
        start_valid    = 1'b0;
        num_bits       = '0;
        vec_valid      = 1'b0;
        vec_tms        = '0;
        vec_tdi        = '0;
        tdo_ready      = 1'b0;
        tck_half_valid = 1'b0;
        tck_half       = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Reset values.
        check("reset_flags",
              {56'd0, start_ready, busy, vec_ready, tdo_valid, tdo_last, jtag_tck, jtag_tms, jtag_tdi},
              64'h80);
        check("reset_tdo_data", {32'd0, tdo_data}, 64'd0);
        check("reset_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});

        // Table-driven commands (vector 0 relies on the reset half-period of 4).
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Zero-length command: no vector request, no TCK, stays idle.
        r0  = rises;
        vc0 = vec_cnt;
        start_valid = 1'b1;
        num_bits    = 32'd0;
        @(negedge clock);
        start_valid = 1'b0;
        check("zero_len_idle", {62'd0, start_ready, busy}, 64'd2);
        repeat (10) @(negedge clock);
        check("zero_len_no_tck", rises - r0, 0);
        check("zero_len_no_vec", vec_cnt - vc0, 0);
        check("zero_len_no_tdo", {63'd0, tdo_valid}, 64'd0);

        // Abort after 5 of 16 bits (half-period is still 2 here).
        exp_half = 2;
        r0 = rises;
        start_valid = 1'b1;
        num_bits    = 32'd16;
        @(negedge clock);
        start_valid = 1'b0;
        for (int k = 0; k < 200 && !vec_ready; k++) @(negedge clock);
        vec_valid = 1'b1;
        vec_tms   = 32'h0;
        vec_tdi   = 32'h0000FFFF;
        @(negedge clock);
        vec_valid = 1'b0;
        for (int k = 0; k < 2000 && (rises - r0) < 5; k++) @(negedge clock);
        check("abort_reached_bit5", rises - r0, 5);
        #2;
        reset = 1'b0;
        #1;
        check("abort_flags",
              {56'd0, start_ready, busy, vec_ready, tdo_valid, tdo_last, jtag_tck, jtag_tms, jtag_tdi},
              64'h80);
        check("abort_tdo_data", {32'd0, tdo_data}, 64'd0);
        check("abort_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Post-abort command uses the reset half-period of 4 again.
        run_vec(post_abort, 99);

        check("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xvc_jtag_shifter.md
Name: xvc_jtag_shifter

Overview:
Bit-level JTAG engine behind the XVC microserver. It executes one XVC "shift:" command and one "settck:" setting. The server supplies a bit count and 32-bit TMS/TDI vector words. The block drives jtag_tck, jtag_tms and jtag_tdi, samples jtag_tdo, and returns packed TDO words over a valid/ready stream. It sits between the server's command decoder and the board's JTAG pins, one clock domain.

Parameters:
WORD_W, 32, width of the vector and TDO words
HALF_W, 16, width of the TCK half-period counter
DEFAULT_HALF, 4, TCK half-period in clocks after reset

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
start_valid  input  1  new shift command offered
start_ready  output  1  engine idle and able to accept a command
num_bits  input  32  number of TCK cycles in the command, sampled on the start handshake
vec_valid  input  1  vector word offered
vec_ready  output  1  engine requests a vector word
vec_tms  input  WORD_W  TMS bits, LSB shifted first
vec_tdi  input  WORD_W  TDI bits, LSB shifted first
tdo_valid  output  1  TDO word available
tdo_ready  input  1  consumer accepts the TDO word
tdo_data  output  WORD_W  captured TDO bits, LSB first
tdo_last  output  1  marks the final TDO word of the command
tck_half_valid  input  1  load a new TCK half-period
tck_half  input  HALF_W  half-period in clocks; 0 is treated as 1
busy  output  1  asserted whenever the engine is not IDLE
jtag_tck  output  1  JTAG clock
jtag_tms  output  1  JTAG TMS
jtag_tdi  output  1  JTAG TDI
jtag_tdo  input  1  JTAG TDO; synchronised externally

Behaviour:
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, EMIT.
- Reset (async assert, sync release) values:
  - state IDLE; start_ready 1; busy 0; vec_ready 0; tdo_valid 0; tdo_data 0; tdo_last 0.
  - jtag_tck 0, jtag_tms 0, jtag_tdi 0.
  - half-period register = DEFAULT_HALF.
- All outputs are registered. start_ready = (state==IDLE). vec_ready = (state==LOAD). tdo_valid = (state==EMIT).
- IDLE:
  - tck_half_valid loads the half-period, with 0 mapped to 1. It is ignored in any other state.
  - On start_valid&&start_ready, latch num_bits into the remaining-bit counter.
  - If num_bits==0, stay in IDLE: no TCK edges, no vector consumed, no TDO word.
  - Otherwise go to LOAD next cycle.
- LOAD: on vec_valid&&vec_ready, latch the TMS/TDI words, clear the TDO shift register and the bit index, and go to SHIFT_LO.
- SHIFT_LO:
  - jtag_tck=0; jtag_tms/jtag_tdi = bit[index] of the latched words, valid from the first SHIFT_LO cycle.
  - Hold for half-period clocks, then go to SHIFT_HI.
  - On the clock edge that raises jtag_tck, sample jtag_tdo into tdo bit[index].
- SHIFT_HI:
  - jtag_tck=1, TMS/TDI held stable, hold for half-period clocks.
  - At the end of the phase, decrement remaining and increment index.
  - If remaining becomes 0 or index wraps at WORD_W, go to EMIT with jtag_tck=0. Otherwise go to SHIFT_LO.
- EMIT:
  - tdo_data holds the word; bits above the last shifted index are 0.
  - tdo_last=1 iff remaining==0.
  - jtag_tck stays 0 indefinitely while tdo_ready is low (backpressure stalls TCK; no bit is lost).
  - On handshake: go to LOAD if remaining>0, else IDLE.
- TMS/TDI keep their last driven value between words and after the command.
- Counter widths:
  - remaining is 32 bits and never underflows.
  - The phase counter counts half-period-1 down to 0.
  - A command of N bits produces exactly N rising TCK edges and ceil(N/32) TDO words.
- Reset assertion mid-command:
  - Abort immediately to reset values. Partial TDO is discarded and no tdo_last is produced.
  - The next command after release behaves normally.
- start_valid outside IDLE is ignored (start_ready is 0). vec_valid outside LOAD is ignored.

Decomposition:
- Package xvc_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT_LO, SHIFT_HI, EMIT);
  - WORD_W and HALF_W defaults;
  - the DEFAULT_HALF constant.
- One natural sub-module is xvc_tck_phase_counter. It loads the half-period, counts down, and pulses phase_done. The rest lives in the top FSM.

Test Plan:
- Reset check: hold reset low mid-run -> start_ready=1, busy=0, tdo_valid=0, jtag_tck/tms/tdi=0; after release, half-period=4.
- Single byte, jtag_tdo looped to jtag_tdi: num_bits=8, tms=0x00, tdi=0xA5 -> exactly 8 TCK rising edges, each phase 4 clocks; one TDO word 0x000000A5 with tdo_last=1; back to IDLE.
- Two words with backpressure: num_bits=40, tdi words 0xDEADBEEF and 0x0000003C, tdo_ready low for 10 cycles at each EMIT -> TCK frozen low during the stall; words 0xDEADBEEF (last=0) and 0x0000003C (last=1); 40 edges total.
- Zero-length command: num_bits=0 -> no vec_ready, no TCK edge, no TDO word; start_ready=1 on the following cycle.
- Half-period change: tck_half=1 in IDLE -> TCK period 2 clocks. tck_half=0 -> treated as 1. tck_half=9 while busy -> ignored, and the current and next command still use the prior value.
- Abort: reset asserted after 5 of 16 bits -> outputs return to reset values within the same cycle. A following num_bits=4, tdi=0x9 run returns 0x00000009 with last=1.
